isr_tracker: RTL



---
 rtl/isr_tracker_pkg.sv | 21 ++
 rtl/isr_tracker_if.sv | 27 ++
 rtl/isr_tracker_m1_cycle_detect.sv | 59 +++++
 rtl/isr_tracker.sv | 113 +++++++++++
 4 files changed

// File: rtl/isr_tracker_pkg.sv
// Shared types and opcode constants for the Z80 instruction-boundary tracker.
package isr_pkg;

  typedef enum logic [1:0] {
    PFX_NONE = 2'd0,
    PFX_CB   = 2'd1,
    PFX_ED   = 2'd2,
    PFX_IDX  = 2'd3
  } prefix_t;

  localparam logic [7:0] OP_CB   = 8'hCB;
  localparam logic [7:0] OP_DD   = 8'hDD;
  localparam logic [7:0] OP_ED   = 8'hED;
  localparam logic [7:0] OP_FD   = 8'hFD;
  localparam logic [7:0] OP_HALT = 8'h76;

  function automatic logic is_index_prefix(input logic [7:0] b);
    return (b == OP_DD) || (b == OP_FD);
  endfunction

endpackage

// File: rtl/isr_tracker_if.sv
// Z80 bus inputs and tracker status outputs; master = CPU side, slave = tracker.
interface isr_tracker_if;
  import isr_pkg::*;

  logic       m1_n;
  logic       mreq_n;
  logic       iorq_n;
  logic       rd_n;
  logic [7:0] data_in;

  logic       new_isr;
  logic       last_isr_untrap;
  logic [7:0] opcode;
  prefix_t    prefix;
  logic       fetch_active;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, data_in,
    input  new_isr, last_isr_untrap, opcode, prefix, fetch_active
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, data_in,
    output new_isr, last_isr_untrap, opcode, prefix, fetch_active
  );

endinterface

// File: rtl/isr_tracker_m1_cycle_detect.sv
// Registers the Z80 control strobes and turns each M1 cycle into start/end/intack pulses.
module m1_cycle_detect (
  input  logic clk,
  input  logic reset,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic iorq_n,
  input  logic rd_n,
  output logic m1_start,
  output logic m1_end,
  output logic is_intack,
  output logic fetch,
  output logic m1_high,
  output logic latch_en
);

  logic m1_q, m1_d, mreq_q, iorq_q;
  logic in_m1, fetch_seen, intack_seen;
  logic intack_raw;

  // m1 history resets low so an M1 already in progress at release never
  // produces a start, and its trailing rise is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_q        <= 1'b0;
      m1_d        <= 1'b0;
      mreq_q      <= 1'b1;
      iorq_q      <= 1'b1;
      in_m1       <= 1'b0;
      fetch_seen  <= 1'b0;
      intack_seen <= 1'b0;
    end else begin
      m1_q   <= m1_n;
      m1_d   <= m1_q;
      mreq_q <= mreq_n;
      iorq_q <= iorq_n;
      if (m1_start)
        in_m1 <= 1'b1;
      else if (m1_q && !m1_d)
        in_m1 <= 1'b0;
      if (m1_start) begin
        fetch_seen  <= fetch;
        intack_seen <= intack_raw;
      end else if (!m1_q) begin
        fetch_seen  <= fetch_seen | fetch;
        intack_seen <= intack_seen | intack_raw;
      end
    end
  end

  assign fetch      = !m1_q && !mreq_q;
  assign intack_raw = !m1_q && !iorq_q && mreq_q;
  assign m1_start   = !m1_q && m1_d;
  assign m1_end     = m1_q && !m1_d && in_m1;
  assign is_intack  = m1_end && intack_seen && !fetch_seen;
  assign m1_high    = m1_q;
  assign latch_en   = !m1_n && !mreq_n && !rd_n;

endmodule

// File: rtl/isr_tracker.sv
// Tracks Z80 prefix state across M1 fetches and flags instruction boundaries
// and untrap-jump completion for the downstream trap/mode controller.
//
// state    | meaning
// PFX_NONE | no prefix pending; next M1 begins a new instruction
// PFX_CB   | CB prefix seen; next M1 byte completes the instruction
// PFX_ED   | ED prefix seen; next M1 byte completes the instruction
// PFX_IDX  | DD/FD seen; waiting for opcode, CB, ED or another DD/FD
module isr_tracker
  import isr_pkg::*;
#(
  parameter logic [7:0] UNTRAP_OPCODE = 8'hC3,
  parameter bit         TRACK_INTACK  = 1'b1
) (
  input logic          clk,
  input logic          reset,
  isr_tracker_if.slave bus
);

  logic       m1_start, m1_end, is_intack, fetch, m1_high, latch_en;
  prefix_t    prefix_q, prefix_n;
  logic       new_isr_q, new_isr_n;
  logic       untrap_q, untrap_n;
  logic [7:0] opcode_q, opcode_n;
  logic [7:0] shadow_q;
  logic       fetch_active_q;

  m1_cycle_detect u_detect (
    .clk       (clk),
    .reset     (reset),
    .m1_n      (bus.m1_n),
    .mreq_n    (bus.mreq_n),
    .iorq_n    (bus.iorq_n),
    .rd_n      (bus.rd_n),
    .m1_start  (m1_start),
    .m1_end    (m1_end),
    .is_intack (is_intack),
    .fetch     (fetch),
    .m1_high   (m1_high),
    .latch_en  (latch_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prefix_q       <= PFX_NONE;
      new_isr_q      <= 1'b1;
      untrap_q       <= 1'b0;
      opcode_q       <= 8'h00;
      shadow_q       <= 8'h00;
      fetch_active_q <= 1'b0;
    end else begin
      prefix_q       <= prefix_n;
      new_isr_q      <= new_isr_n;
      untrap_q       <= untrap_n;
      opcode_q       <= opcode_n;
      if (latch_en)
        shadow_q <= bus.data_in;
      fetch_active_q <= fetch || (fetch_active_q && !m1_high);
    end
  end

  // Outputs only move on an M1 end, so they hold while m1_n is low.
  always_comb begin
    prefix_n  = prefix_q;
    new_isr_n = new_isr_q;
    untrap_n  = untrap_q;
    opcode_n  = opcode_q;
    if (m1_end) begin
      new_isr_n = 1'b1;
      untrap_n  = 1'b0;
      prefix_n  = PFX_NONE;
      if (!(is_intack && TRACK_INTACK)) begin
        opcode_n = shadow_q;
        case (prefix_q)
          PFX_NONE: begin
            if (is_index_prefix(shadow_q)) begin
              prefix_n  = PFX_IDX;
              new_isr_n = 1'b0;
            end else if (shadow_q == OP_CB) begin
              prefix_n  = PFX_CB;
              new_isr_n = 1'b0;
            end else if (shadow_q == OP_ED) begin
              prefix_n  = PFX_ED;
              new_isr_n = 1'b0;
            end else begin
              untrap_n = (shadow_q == UNTRAP_OPCODE);
            end
          end
          // DDCB/FDCB: displacement and opcode arrive as plain reads, so
          // the CB byte already completes the instruction as far as M1 goes.
          PFX_IDX: begin
            if (is_index_prefix(shadow_q)) begin
              prefix_n  = PFX_IDX;
              new_isr_n = 1'b0;
            end else if (shadow_q == OP_ED) begin
              prefix_n  = PFX_ED;
              new_isr_n = 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.new_isr         = new_isr_q;
  assign bus.last_isr_untrap = untrap_q;
  assign bus.opcode          = opcode_q;
  assign bus.prefix          = prefix_q;
  assign bus.fetch_active    = fetch_active_q;

endmodule
